farrow_interp_mc: RTL and testbench

Parametrised, pipelined Farrow fractional-delay interpolator for the timing-recovery path. It supports selectable linear or piecewise-parabolic (alpha = 0.5) interpolation, time-interleaved channels with independent history, mu clamping and output saturation with a flag. It is the drop-in successor to the single-channel fixed-format Farrow stage and sits between the matched filter and the symbol-timing loop.

---
 rtl/farrow_interp_mc.sv | 212 +++++++++++++++++++++
 tb/tb_farrow_interp_mc.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/farrow_interp_mc.sv
// Multi-channel pipelined Farrow fractional-delay interpolator (linear / parabolic alpha=0.5).
// Per-channel 4-tap history; 5-cycle latency from sample accept to registered output.
module farrow_interp_mc #(
    parameter int DW   = 16,
    parameter int FRAC = 14,
    parameter int NCH  = 1,
    parameter int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable_in,
    input  logic                   mode_in,
    input  logic [CHW-1:0]         ch_in,
    input  logic signed [FRAC+1:0] mu_in,
    input  logic signed [DW-1:0]   data_in,
    output logic signed [DW-1:0]   data_out,
    output logic                   enable_out,
    output logic [CHW-1:0]         ch_out,
    output logic                   sat_out
);
    localparam int MUC = FRAC + 1;
    localparam int S2W = DW + 2;
    localparam int S1W = DW + 3;
    localparam int DFW = DW + 1;
    localparam int PW1 = DW + FRAC + 4;
    localparam int PW2 = PW1 + FRAC + 2;

    localparam logic [MUC-1:0]        MU_ONE = MUC'(1) << FRAC;
    localparam logic signed [PW2-1:0] RND_P  = PW2'(1) << (2 * FRAC);
    localparam logic signed [PW2-1:0] RND_L  = PW2'(1) << (FRAC - 1);
    localparam logic signed [PW2-1:0] Y_MAX  = (PW2'(1) << (DW - 1)) - PW2'(1);
    localparam logic signed [PW2-1:0] Y_MIN  = -(PW2'(1) << (DW - 1));

    logic signed [DW-1:0] hist_q [NCH][4];
    logic signed [DW-1:0] hist_d [NCH][4];
    logic                 hit, acc;
    logic signed [DW-1:0] tap0, tap1, tap2;
    logic [MUC-1:0]       mu_clamp;

    logic                 v1_q, v1_d, mode1_q, mode1_d;
    logic [CHW-1:0]       ch1_q, ch1_d;
    logic [MUC-1:0]       mu1_q, mu1_d;
    logic signed [DW-1:0] x0_1_q, x0_1_d, x1_1_q, x1_1_d, x2_1_q, x2_1_d, x3_1_q, x3_1_d;

    logic                  v2_q, v2_d, mode2_q, mode2_d;
    logic [CHW-1:0]        ch2_q, ch2_d;
    logic [MUC-1:0]        mu2_q, mu2_d;
    logic signed [DW-1:0]  x2_2_q, x2_2_d;
    logic signed [S2W-1:0] s2_2_q, s2_2_d;
    logic signed [S1W-1:0] s1_2_q, s1_2_d;
    logic signed [DFW-1:0] dif_2_q, dif_2_d;

    logic                  v3_q, v3_d, mode3_q, mode3_d;
    logic [CHW-1:0]        ch3_q, ch3_d;
    logic [MUC-1:0]        mu3_q, mu3_d;
    logic signed [DW-1:0]  x2_3_q, x2_3_d;
    logic signed [PW1-1:0] p1_3_q, p1_3_d;

    logic                  v4_q, v4_d, mode4_q, mode4_d;
    logic [CHW-1:0]        ch4_q, ch4_d;
    logic signed [DW-1:0]  x2_4_q, x2_4_d;
    logic signed [PW2-1:0] p2_4_q, p2_4_d;

    logic                  v5_q, v5_d;
    logic [CHW-1:0]        ch5_q, ch5_d;
    logic signed [PW2-1:0] y5_q, y5_d;

    logic                  enable_out_q, enable_out_d, sat_out_q, sat_out_d;
    logic [CHW-1:0]        ch_out_q, ch_out_d;
    logic signed [DW-1:0]  data_out_q, data_out_d;

    // Sign-extended operands so every arithmetic node is evaluated at full width.
    logic signed [S1W-1:0] e0, e1, e2, e3;
    logic signed [PW1-1:0] s2_w, s1_w, dif_w, mu_w1;
    logic signed [PW2-1:0] p1_w2, mu_w2, x2_w, rnd_p, rnd_l;

    assign e0    = S1W'(x0_1_q);
    assign e1    = S1W'(x1_1_q);
    assign e2    = S1W'(x2_1_q);
    assign e3    = S1W'(x3_1_q);
    assign s2_w  = PW1'(s2_2_q);
    assign s1_w  = PW1'(s1_2_q);
    assign dif_w = PW1'(dif_2_q);
    assign mu_w1 = PW1'(mu2_q);
    assign p1_w2 = PW2'(p1_3_q);
    assign mu_w2 = PW2'(mu3_q);
    assign x2_w  = PW2'(x2_4_q);
    assign rnd_p = (p2_4_q + RND_P) >>> (2 * FRAC + 1);
    assign rnd_l = (p2_4_q + RND_L) >>> FRAC;

    always_comb begin
        hit  = 1'b0;
        tap0 = '0;
        tap1 = '0;
        tap2 = '0;
        for (int c = 0; c < NCH; c++) begin
            if (ch_in == CHW'(c)) begin
                hit  = 1'b1;
                tap0 = hist_q[c][0];
                tap1 = hist_q[c][1];
                tap2 = hist_q[c][2];
            end
        end
        acc    = enable_in & hit;
        hist_d = hist_q;
        for (int c = 0; c < NCH; c++) begin
            if (acc && ch_in == CHW'(c)) begin
                hist_d[c][0] = data_in;
                hist_d[c][1] = hist_q[c][0];
                hist_d[c][2] = hist_q[c][1];
                hist_d[c][3] = hist_q[c][2];
            end
        end

        if (mu_in[FRAC+1])
            mu_clamp = '0;
        else if (mu_in[FRAC:0] > MU_ONE)
            mu_clamp = MU_ONE;
        else
            mu_clamp = mu_in[FRAC:0];

        v1_d    = acc;
        mode1_d = mode_in;
        ch1_d   = ch_in;
        mu1_d   = mu_clamp;
        x0_1_d  = data_in;
        x1_1_d  = tap0;
        x2_1_d  = tap1;
        x3_1_d  = tap2;

        v2_d    = v1_q;
        mode2_d = mode1_q;
        ch2_d   = ch1_q;
        mu2_d   = mu1_q;
        x2_2_d  = x2_1_q;
        s2_2_d  = S2W'(e0 - e1 - e2 + e3);
        s1_2_d  = (e1 <<< 1) + e1 - e0 - e2 - e3;
        dif_2_d = DFW'(e1 - e2);

        v3_d    = v2_q;
        mode3_d = mode2_q;
        ch3_d   = ch2_q;
        mu3_d   = mu2_q;
        x2_3_d  = x2_2_q;
        p1_3_d  = mode2_q ? (s2_w * mu_w1 + (s1_w <<< FRAC)) : (dif_w * mu_w1);

        v4_d    = v3_q;
        mode4_d = mode3_q;
        ch4_d   = ch3_q;
        x2_4_d  = x2_3_q;
        p2_4_d  = mode3_q ? (p1_w2 * mu_w2) : p1_w2;

        v5_d    = v4_q;
        ch5_d   = ch4_q;
        y5_d    = (mode4_q ? rnd_p : rnd_l) + x2_w;

        // Outputs hold their last values across bubbles.
        enable_out_d = v5_q;
        data_out_d   = data_out_q;
        ch_out_d     = ch_out_q;
        sat_out_d    = sat_out_q;
        if (v5_q) begin
            ch_out_d = ch5_q;
            if (y5_q > Y_MAX) begin
                data_out_d = Y_MAX[DW-1:0];
                sat_out_d  = 1'b1;
            end else if (y5_q < Y_MIN) begin
                data_out_d = Y_MIN[DW-1:0];
                sat_out_d  = 1'b1;
            end else begin
                data_out_d = y5_q[DW-1:0];
                sat_out_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++)
                for (int t = 0; t < 4; t++)
                    hist_q[c][t] <= '0;
            v1_q <= 1'b0; mode1_q <= 1'b0; ch1_q <= '0; mu1_q <= '0;
            x0_1_q <= '0; x1_1_q <= '0; x2_1_q <= '0; x3_1_q <= '0;
            v2_q <= 1'b0; mode2_q <= 1'b0; ch2_q <= '0; mu2_q <= '0;
            x2_2_q <= '0; s2_2_q <= '0; s1_2_q <= '0; dif_2_q <= '0;
            v3_q <= 1'b0; mode3_q <= 1'b0; ch3_q <= '0; mu3_q <= '0;
            x2_3_q <= '0; p1_3_q <= '0;
            v4_q <= 1'b0; mode4_q <= 1'b0; ch4_q <= '0; x2_4_q <= '0; p2_4_q <= '0;
            v5_q <= 1'b0; ch5_q <= '0; y5_q <= '0;
            enable_out_q <= 1'b0; data_out_q <= '0; ch_out_q <= '0; sat_out_q <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++)
                for (int t = 0; t < 4; t++)
                    hist_q[c][t] <= hist_d[c][t];
            v1_q <= v1_d; mode1_q <= mode1_d; ch1_q <= ch1_d; mu1_q <= mu1_d;
            x0_1_q <= x0_1_d; x1_1_q <= x1_1_d; x2_1_q <= x2_1_d; x3_1_q <= x3_1_d;
            v2_q <= v2_d; mode2_q <= mode2_d; ch2_q <= ch2_d; mu2_q <= mu2_d;
            x2_2_q <= x2_2_d; s2_2_q <= s2_2_d; s1_2_q <= s1_2_d; dif_2_q <= dif_2_d;
            v3_q <= v3_d; mode3_q <= mode3_d; ch3_q <= ch3_d; mu3_q <= mu3_d;
            x2_3_q <= x2_3_d; p1_3_q <= p1_3_d;
            v4_q <= v4_d; mode4_q <= mode4_d; ch4_q <= ch4_d; x2_4_q <= x2_4_d; p2_4_q <= p2_4_d;
            v5_q <= v5_d; ch5_q <= ch5_d; y5_q <= y5_d;
            enable_out_q <= enable_out_d; data_out_q <= data_out_d;
            ch_out_q <= ch_out_d; sat_out_q <= sat_out_d;
        end
    end

    assign data_out   = data_out_q;
    assign enable_out = enable_out_q;
    assign ch_out     = ch_out_q;
    assign sat_out    = sat_out_q;
endmodule

// File: tb/tb_farrow_interp_mc.sv
// Bench for farrow_interp_mc: a single-channel and a three-channel instance share stimulus;
// a per-channel arithmetic model with a 5-cycle expectation delay line is checked every cycle.
module tb_farrow_interp_mc;
    localparam int FRAC = 14;

    typedef struct {
        bit     v;
        longint y;
        int     ch;
        bit     sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst, en, mode;
    logic signed [15:0] mu_in, data_in;
    logic       ch_a;
    logic [1:0] ch_b;
    logic signed [15:0] dout_a, dout_b;
    logic eo_a, eo_b, sat_a, sat_b;
    logic       ch_out_a;
    logic [1:0] ch_out_b;

    int   n_pass = 0, n_total = 0;
    bit   chk_on = 1'b0;
    exp_t pipe [2][6];
    exp_t hold [2];
    longint hist [2][3][4];
    exp_t obs_a [$];
    exp_t obs_b [$];

    farrow_interp_mc #(.DW(16), .FRAC(14), .NCH(1)) u_dut_a (
        .clk(clk), .rst(rst), .enable_in(en), .mode_in(mode), .ch_in(ch_a),
        .mu_in(mu_in), .data_in(data_in), .data_out(dout_a), .enable_out(eo_a),
        .ch_out(ch_out_a), .sat_out(sat_a));

    farrow_interp_mc #(.DW(16), .FRAC(14), .NCH(3)) u_dut_b (
        .clk(clk), .rst(rst), .enable_in(en), .mode_in(mode), .ch_in(ch_b),
        .mu_in(mu_in), .data_in(data_in), .data_out(dout_b), .enable_out(eo_b),
        .ch_out(ch_out_b), .sat_out(sat_b));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int d, input logic signed [63:0] act,
                       input logic signed [63:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s dut%0d: got %0d, expected %0d", name, d, act, expv);
    endtask

    function automatic longint interp(input bit par, input longint mu, input longint x0,
                                      input longint x1, input longint x2, input longint x3);
        longint s1, s2, p;
        if (!par) return x2 + (((x1 - x2) * mu + (64'sd1 <<< (FRAC - 1))) >>> FRAC);
        s2 = x0 - x1 - x2 + x3;
        s1 = -x0 + 3 * x1 - x2 - x3;
        p  = (s2 * mu + s1 * (64'sd1 <<< FRAC)) * mu;
        return x2 + ((p + (64'sd1 <<< (2 * FRAC))) >>> (2 * FRAC + 1));
    endfunction

    task automatic model_step(input int d, input int nch, input int chv);
        exp_t   e;
        longint m, y;
        for (int i = 5; i > 0; i--) pipe[d][i] = pipe[d][i-1];
        e.v = 1'b0; e.y = 0; e.ch = 0; e.sat = 1'b0;
        if (rst) begin
            for (int i = 0; i < 6; i++) pipe[d][i] = e;
            for (int c = 0; c < 3; c++)
                for (int t = 0; t < 4; t++) hist[d][c][t] = 0;
            hold[d] = e;
        end else begin
            if (en && chv < nch) begin
                for (int t = 3; t > 0; t--) hist[d][chv][t] = hist[d][chv][t-1];
                hist[d][chv][0] = longint'(data_in);
                m = longint'(mu_in);
                if (m < 0) m = 0;
                if (m > 16384) m = 16384;
                y = interp(mode, m, hist[d][chv][0], hist[d][chv][1],
                           hist[d][chv][2], hist[d][chv][3]);
                e.v = 1'b1;
                e.ch = chv;
                if (y > 32767) begin e.y = 32767; e.sat = 1'b1; end
                else if (y < -32768) begin e.y = -32768; e.sat = 1'b1; end
                else e.y = y;
            end
            pipe[d][0] = e;
            if (pipe[d][5].v) hold[d] = pipe[d][5];
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 1, int'(ch_a));
        model_step(1, 3, int'(ch_b));
    end

    task automatic check_dut(input int d, input logic e, input logic signed [15:0] dat,
                             input logic [1:0] ch, input logic sat);
        exp_t o;
        chk("enable_out", d, e, pipe[d][5].v);
        chk("data_out", d, dat, hold[d].y);
        chk("ch_out", d, ch, hold[d].ch);
        chk("sat_out", d, sat, hold[d].sat);
        if (e === 1'b1) begin
            o.v = 1'b1; o.y = longint'(dat); o.ch = int'(ch); o.sat = sat;
            if (d == 0) obs_a.push_back(o);
            else obs_b.push_back(o);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check_dut(0, eo_a, dout_a, {1'b0, ch_out_a}, sat_a);
            check_dut(1, eo_b, dout_b, ch_out_b, sat_b);
        end
    end

    task automatic put(input bit e, input bit m, input int mu, input int dat, input int ch);
        en      = e;
        mode    = m;
        mu_in   = 16'(mu);
        data_in = 16'(dat);
        ch_b    = 2'(ch);
        ch_a    = (ch == 0) ? 1'b0 : 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        put(0, 0, 0, 0, 0);
        rst = 1'b0;
        obs_a.delete();
        obs_b.delete();
    endtask

    initial begin
        rst = 1'b1;
        put(0, 0, 0, 0, 0);
        rst = 1'b0;
        chk_on = 1'b1;
        chk("rst_enable", 0, eo_a, 0);
        chk("rst_data", 1, dout_b, 0);

        // linear ramp, mu=0 -> x2
        do_reset();
        for (int k = 0; k < 8; k++) put(1, 0, 0, 16 * k, 0);
        idle(7);
        chk("lin_count", 0, obs_a.size(), 8);
        chk("lin_k2", 0, obs_a[2].y, 0);
        chk("lin_k5", 0, obs_a[5].y, 48);
        chk("lin_k7", 1, obs_b[7].y, 80);

        // parabolic ramp, mu=0.5 and mu=1
        do_reset();
        for (int k = 0; k < 8; k++) put(1, 1, 8192, 16 * k, 0);
        idle(7);
        chk("par_half_k3", 0, obs_a[3].y, 24);
        chk("par_half_k7", 0, obs_a[7].y, 88);
        do_reset();
        for (int k = 0; k < 8; k++) put(1, 1, 16384, 16 * k, 0);
        idle(7);
        chk("par_one_k5", 0, obs_a[5].y, 64);

        // saturation, positive and negative
        do_reset();
        put(1, 1, 8192, 0, 0); put(1, 1, 8192, 32767, 0);
        put(1, 1, 8192, 32767, 0); put(1, 1, 8192, 0, 0);
        idle(7);
        chk("sat_count", 0, obs_a.size(), 4);
        chk("sat_o2", 0, obs_a[1].y, -4096);
        chk("sat_o2_flag", 0, obs_a[1].sat, 0);
        chk("sat_pos", 0, obs_a[3].y, 32767);
        chk("sat_pos_flag", 0, obs_a[3].sat, 1);
        do_reset();
        put(1, 1, 8192, 0, 0); put(1, 1, 8192, -32768, 0);
        put(1, 1, 8192, -32768, 0); put(1, 1, 8192, 0, 0);
        idle(7);
        chk("sat_neg", 1, obs_b[3].y, -32768);
        chk("sat_neg_flag", 1, obs_b[3].sat, 1);

        // mu clamping and dropped out-of-range channel
        do_reset();
        put(1, 0, 0, 100, 0); put(1, 0, 0, 200, 0); put(1, 0, 0, 300, 0);
        put(1, 0, -5, 400, 0);
        put(1, 0, 20000, 500, 0);
        put(1, 0, 0, 9999, 3);
        put(1, 0, 16384, 600, 0);
        idle(7);
        chk("drop_count_a", 0, obs_a.size(), 6);
        chk("drop_count_b", 1, obs_b.size(), 6);
        chk("mu_neg", 0, obs_a[3].y, 200);
        chk("mu_big", 0, obs_a[4].y, 400);
        chk("drop_hist", 1, obs_b[5].y, 500);

        // two interleaved channels, random mu and mode
        do_reset();
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0)
                put(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 20000)) - 2000, 16 * (i / 2), 0);
            else
                put(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 20000)) - 2000, -100, 1);
        end
        idle(7);
        chk("ilv_count", 1, obs_b.size(), 24);
        for (int i = 0; i < obs_b.size(); i++) begin
            chk("ilv_ch", 1, obs_b[i].ch, i % 2);
            if (i % 2 == 1 && i >= 7) chk("ilv_const", 1, obs_b[i].y, -100);
        end

        // reset with three samples in flight
        do_reset();
        put(1, 1, 8192, 1000, 0); put(1, 1, 8192, 2000, 0); put(1, 1, 8192, 3000, 0);
        rst = 1'b1;
        put(0, 0, 0, 0, 0);
        rst = 1'b0;
        put(1, 0, 16384, 777, 0);
        idle(8);
        chk("midrst_count", 0, obs_a.size(), 1);
        chk("midrst_val", 0, obs_a[0].y, 0);
        chk("midrst_count_b", 1, obs_b.size(), 1);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
